sram_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester and the data requester (EX issue / MEM return) of the pipeline. It arbitrates address-phase requests, tracks outstanding transactions in issue order, and routes each response (`data_ok`, `rdata`) back to the requester that issued it. It sits between the pipeline stages and the memory bridge and adds no latency on either phase.

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/owner_fifo.sv | 63 ++++++
 rtl/sram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: owner tags and parameter defaults.
package sram_arb_pkg;

  typedef logic owner_t;

  localparam owner_t OWN_INST = 1'b0;
  localparam owner_t OWN_DATA = 1'b1;

  localparam int DEF_MAX_OUTST  = 4;
  localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of owner tags, one entry per accepted-but-unanswered transaction.
module owner_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTST,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  owner_t      push_tag,
  input  logic        pop,
  output owner_t      head_tag,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty
);

  owner_t        tag_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_tag = tag_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) tag_q[wr_ptr_q] <= push_tag;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters, routing
// responses back in issue order with no added latency on either phase.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic          lock_q, lock_d;
  owner_t        lock_owner_q, lock_owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          proto_err_q, proto_err_d;

  owner_t        owner;
  logic          owner_req;
  logic          accept;
  logic          pop;
  owner_t        head_tag;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  always_comb begin
    owner = OWN_DATA;
    if (lock_q)
      owner = lock_owner_q;
    else if (inst_req && !data_req)
      owner = OWN_INST;
    else if (inst_req && data_req && (starve_q == SW'(STARVE_LIM)))
      owner = OWN_INST;
  end

  assign owner_req = (owner == OWN_INST) ? inst_req : data_req;
  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign mem_req   = owner_req && !fifo_full;
  assign accept    = mem_req && mem_addr_ok;

  always_comb begin
    if (owner == OWN_INST) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = accept && (owner == OWN_INST);
  assign data_addr_ok = accept && (owner == OWN_DATA);

  assign pop          = mem_data_ok && (fifo_count != '0);
  assign inst_data_ok = pop && (head_tag == OWN_INST);
  assign data_data_ok = pop && (head_tag == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign proto_err    = proto_err_q;

  always_comb begin
    lock_d       = mem_req && !mem_addr_ok;
    lock_owner_d = owner;

    starve_d = starve_q;
    if (!inst_req || (accept && (owner == OWN_INST)))
      starve_d = '0;
    else if (accept && (starve_q != SW'(STARVE_LIM)))
      starve_d = starve_q + SW'(1);

    proto_err_d = proto_err_q || (mem_data_ok && fifo_empty);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_DATA;
      starve_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      proto_err_q  <= proto_err_d;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (owner),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scenario bench for sram_port_arbiter: expected owner tags are queued at issue
// and checked against the routed data_ok when the memory answers.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb[$];           // expected owner of each outstanding transaction, 1 = data
  logic [1:0] want;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_OUTST(4), .STARVE_LIM(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {inst_data_ok, data_data_ok} for a response; nothing expected when empty.
  function automatic logic [1:0] exp_resp();
    if (sb.size() == 0) return 2'b00;
    return sb.pop_front() ? 2'b01 : 2'b10;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    #3;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err});
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
      n_bad++; $display("FAIL single_accept: got %b want 110", {mem_req, inst_addr_ok, data_addr_ok});
    end
    n_cmp++;
    if (mem_addr !== 32'h1C00_0000) begin
      n_bad++; $display("FAIL single_addr: got %h want 1c000000", mem_addr);
    end
    sb.push_back(1'b0);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h02C0_0000;
    #1;
    want = exp_resp();
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== want) begin
      n_bad++; $display("FAIL single_route: got %b want %b", {inst_data_ok, data_data_ok}, want);
    end
    n_cmp++;
    if (inst_rdata !== 32'h02C0_0000) begin
      n_bad++; $display("FAIL single_rdata: got %h want 02c00000", inst_rdata);
    end
    $display("single_read: route=%b rdata=%h", {inst_data_ok, data_data_ok}, inst_rdata);
    tick();
    mem_data_ok = 0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    inst_req = 1; inst_addr = 32'h1C00_0040; data_req = 1; data_addr = 32'h8000_0000;
    mem_addr_ok = 1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01 || mem_addr !== 32'h8000_0000) begin
      n_bad++; $display("FAIL simul_first: got ok=%b addr=%h want ok=01 addr=80000000",
                        {inst_addr_ok, data_addr_ok}, mem_addr);
    end
    sb.push_back(1'b1);
    tick();
    data_req = 0;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1C00_0040) begin
      n_bad++; $display("FAIL simul_second: got ok=%b addr=%h want ok=10 addr=1c000040",
                        {inst_addr_ok, data_addr_ok}, mem_addr);
    end
    sb.push_back(1'b0);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      rd = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
      mem_data_ok = 1; mem_rdata = rd;
      #1;
      want = exp_resp();
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== want || (want[0] ? data_rdata : inst_rdata) !== rd) begin
        n_bad++; $display("FAIL simul_resp%0d: got route=%b rdata=%h want route=%b rdata=%h",
                          k, {inst_data_ok, data_data_ok}, want[0] ? data_rdata : inst_rdata, want, rd);
      end
      $display("simultaneous resp%0d: route=%b", k, {inst_data_ok, data_data_ok});
      tick();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_lock();
    // Data holds the port while inst arrives.
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    data_wstrb = 4'hF; inst_addr = 32'h1C00_0100; inst_wdata = 32'h0; inst_wstrb = 4'h0;
    mem_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) inst_req = 1;
      #1;
      n_cmp++;
      if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100 ||
          {mem_wr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF}) begin
        n_bad++; $display("FAIL lock_hold_data%0d: got req/ok=%b addr=%h wdata=%h wstrb=%h want 100 80000010 deadbeef f",
                          i, {mem_req, inst_addr_ok, data_addr_ok}, mem_addr, mem_wdata, mem_wstrb);
      end
      tick();
    end
    mem_addr_ok = 1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      n_bad++; $display("FAIL lock_data_accept: got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    sb.push_back(1'b1);
    tick();
    data_req = 0; data_wr = 0;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL lock_inst_after: got %b want 10", {inst_addr_ok, data_addr_ok});
    end
    sb.push_back(1'b0);
    tick();
    // Inst holds the port while data arrives; unlocked, data would win.
    inst_req = 1; inst_addr = 32'h1C00_0200; mem_addr_ok = 0;
    tick();
    data_req = 1;
    #1;
    n_cmp++;
    if (mem_addr !== 32'h1C00_0200 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin
      n_bad++; $display("FAIL lock_hold_inst: got addr=%h ok=%b want 1c000200 00",
                        mem_addr, {inst_addr_ok, data_addr_ok});
    end
    tick();
    mem_addr_ok = 1;
    #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL lock_inst_accept: got %b want 10", {inst_addr_ok, data_addr_ok});
    end
    sb.push_back(1'b0);
    $display("lock: inst accepted after hold, ok=%b", {inst_addr_ok, data_addr_ok});
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      mem_data_ok = 1;
      #1;
      want = exp_resp();
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== want) begin
        n_bad++; $display("FAIL lock_resp%0d: got %b want %b", k, {inst_data_ok, data_data_ok}, want);
      end
      tick();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_full();
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h0000_0100 + 32'(i * 4);
      #1;
      n_cmp++;
      if (data_addr_ok !== 1'b1) begin
        n_bad++; $display("FAIL full_fill%0d: got %b want 1", i, data_addr_ok);
      end
      sb.push_back(1'b1);
      tick();
    end
    data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0300;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      n_bad++; $display("FAIL full_block: got %b want 00", {mem_req, inst_addr_ok});
    end
    tick();
    mem_data_ok = 1;
    #1;
    want = exp_resp();
    n_cmp++;
    if ({mem_req, inst_addr_ok, inst_data_ok, data_data_ok} !== {2'b00, want}) begin
      n_bad++; $display("FAIL full_pop_same_cycle: got %b want %b",
                        {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}, {2'b00, want});
    end
    tick();
    mem_data_ok = 0;
    #1;
    n_cmp++;
    if ({mem_req, inst_addr_ok} !== 2'b11) begin
      n_bad++; $display("FAIL full_next_accept: got %b want 11", {mem_req, inst_addr_ok});
    end
    sb.push_back(1'b0);
    $display("full: accept after pop, ok=%b", {mem_req, inst_addr_ok});
    tick();
    inst_req = 0; mem_addr_ok = 0;
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1;
      #1;
      want = exp_resp();
      n_cmp++;
      if ({inst_data_ok, data_data_ok} !== want) begin
        n_bad++; $display("FAIL full_drain%0d: got %b want %b", k, {inst_data_ok, data_data_ok}, want);
      end
      tick();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_starvation();
    bit own;
    for (int c = 0; c < 10; c++) begin
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = (c > 0);
      #1;
      own = (c % 5 != 4);
      n_cmp++;
      if ({inst_addr_ok, data_addr_ok} !== (own ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL starve_grant%0d: got %b want %b", c, {inst_addr_ok, data_addr_ok},
                          own ? 2'b01 : 2'b10);
      end
      if (c > 0) begin
        want = exp_resp();
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== want) begin
          n_bad++; $display("FAIL starve_resp%0d: got %b want %b", c, {inst_data_ok, data_data_ok}, want);
        end
      end
      sb.push_back(own);
      $display("starvation cycle %0d: grant=%b", c, {inst_addr_ok, data_addr_ok});
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    want = exp_resp();
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== want) begin
      n_bad++; $display("FAIL starve_last_resp: got %b want %b", {inst_data_ok, data_data_ok}, want);
    end
    tick();
    mem_data_ok = 0;
  endtask

  task automatic test_error_reset();
    mem_data_ok = 1;
    #1;
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_bad++; $display("FAIL err_no_route: got %b want 00", {inst_data_ok, data_data_ok});
    end
    tick();
    mem_data_ok = 0;
    #1;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++; $display("FAIL err_set: got %b want 1", proto_err);
    end
    tick();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %b want 1", proto_err);
    end
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (data_addr_ok !== 1'b1) begin
        n_bad++; $display("FAIL rst_prefill%0d: got %b want 1", i, data_addr_ok);
      end
      tick();
    end
    data_req = 0; mem_addr_ok = 0;
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({proto_err, mem_req} !== 2'b00) begin
      n_bad++; $display("FAIL rst_async: got err/req=%b want 00", {proto_err, mem_req});
    end
    sb.delete();
    $display("reset mid-operation: err/req=%b", {proto_err, mem_req});
    @(negedge clk);
    resetn = 1'b1;
    tick();
    // Outstanding tags are gone: a full window of four accepts fits again.
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (data_addr_ok !== (i < 4)) begin
        n_bad++; $display("FAIL rst_window%0d: got %b want %b", i, data_addr_ok, i < 4);
      end
      tick();
    end
    data_req = 0; mem_addr_ok = 0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    mem_data_ok = 1;
    #1;
    want = exp_resp();
    n_cmp++;
    if ({inst_data_ok, data_data_ok} !== want) begin
      n_bad++; $display("FAIL rst_stale_resp: got %b want %b", {inst_data_ok, data_data_ok}, want);
    end
    tick();
    mem_data_ok = 0;
    #1;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++; $display("FAIL rst_stale_err: got %b want 1", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_lock();
    test_full();
    test_starvation();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
